motor_status_scanner: RTL and testbench
=======================================

MOTOR_STATUS_SCANNER -- requirements
Module: motor_status_scanner

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 2, giving the cycles the selection is held before each sample (legal 1..15).
REQ-002 The block SHALL have parameter DEBOUNCE, default 3, giving the consecutive disagreeing samples needed to change a motor flag (legal 1..15).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high runs continuous scanning; low parks the block in IDLE.
REQ-006 result_in  input  8  overspeed code from the flight control stage: 0xFF means overspeed, 0x00 means normal, any other value is invalid.
REQ-007 s1  output  1  motor select MSB, registered, driven to the flight control stage.
REQ-008 s2  output  1  motor select LSB, registered; {s1,s2} is the motor index 0..3.
REQ-009 ovs_flag  output  4  debounced overspeed flag per motor; bit n is motor n.
REQ-010 alarm  output  1  registered OR of ovs_flag.
REQ-011 scan_done  output  1  one-cycle pulse when a full 4-motor scan completes.
REQ-012 code_err  output  1  sticky flag, set by any invalid sample and cleared only by reset.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SETTLE and SAMPLE.
REQ-014 In IDLE with enable high, the FSM SHALL go to SETTLE with channel index ch=0 and settle counter 0 at the next edge.
REQ-015 {s1,s2} SHALL equal the registered ch at all times, including in IDLE (where ch=0).
REQ-016 SETTLE SHALL last exactly SETTLE_CYC cycles and then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle, during which result_in is classified.
REQ-018 On leaving SAMPLE, ch SHALL increment modulo 4 and the FSM SHALL re-enter SETTLE with counter 0; each motor therefore takes SETTLE_CYC+1 cycles and a scan takes 4*(SETTLE_CYC+1) cycles (12 at defaults).
REQ-019 Debounce, per motor, one 4-bit counter dbc[n]: a valid sample equal to ovs_flag[n] SHALL clear dbc[n].
REQ-020 A valid sample differing from ovs_flag[n] SHALL increment dbc[n]; when the incremented value equals DEBOUNCE, ovs_flag[n] SHALL toggle and dbc[n] SHALL clear in the same edge.
REQ-021 An invalid sample SHALL leave ovs_flag[n] and dbc[n] unchanged and SHALL set code_err.
REQ-022 Timing of flag updates: ovs_flag, code_err and alarm SHALL update on the edge ending SAMPLE; alarm SHALL reflect the new flags on that same edge (alarm computed from next-state flags).
REQ-023 scan_done SHALL be high for exactly the cycle after the SAMPLE of ch=3.
REQ-024 enable low in any state SHALL force IDLE at the next edge with ch=0, settle counter=0 and no sample taken; ovs_flag, dbc, code_err and alarm SHALL be retained.
REQ-025 Re-enabling after REQ-024 SHALL always restart the scan at motor 0.
REQ-026 If enable falls during the SAMPLE cycle, that sample SHALL be discarded and scan_done SHALL NOT pulse.

Reset
REQ-027 While rst_n is low, the block SHALL be in IDLE with ch=0, s1=s2=0, settle counter=0, all dbc=0, ovs_flag=4'b0000, alarm=0, scan_done=0 and code_err=0, independent of clk.
REQ-028 A reset asserted mid-scan SHALL abort immediately; after rst_n rises, operation SHALL resume per REQ-014 on the first edge where enable is high.

Verification
REQ-029 Defaults, enable=1, result_in=0x00 throughout -> {s1,s2} steps 0,1,2,3 every 3 cycles; scan_done pulses every 12 cycles; ovs_flag=0; alarm=0.
REQ-030 result_in=0xFF whenever sel=2 -> ovs_flag[2] sets on the edge ending the 3rd scan's motor-2 SAMPLE; alarm=1 on the same edge; other flags stay 0.
REQ-031 Motor 1 pattern 0xFF,0xFF,0x00,0xFF,0xFF,0xFF across scans -> ovs_flag[1] sets only after the 6th scan (the 0x00 sample clears dbc).
REQ-032 result_in=0x5A at sel=0 for one sample -> code_err=1 and remains 1; ovs_flag[0] and dbc[0] unchanged.
REQ-033 enable dropped while sel=2 in SETTLE, raised 5 cycles later -> IDLE with sel=0; restart samples motor 0 after 3 cycles; no scan_done until a full 0..3 scan completes; existing flags retained.
REQ-034 rst_n pulsed low mid-SETTLE with ovs_flag=4'b1010 -> all outputs zero asynchronously; scan resumes at motor 0.

Source files
------------

// File: rtl/motor_status_scanner.sv
// Motor overspeed status scanner.
// Walks a 2-bit motor select across four motors and holds each selection
// for SETTLE_CYC cycles. It then classifies the returned overspeed code and
// keeps a debounced overspeed flag per motor.
//
// state  | meaning
// IDLE   | parked; select held at motor 0, no sampling
// SETTLE | select driven, waiting for the flight control stage to settle
// SAMPLE | result_in classified for the selected motor

module motor_status_scanner #(
    parameter int SETTLE_CYC = 2,
    parameter int DEBOUNCE   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] result_in,
    output logic       s1,
    output logic       s2,
    output logic [3:0] ovs_flag,
    output logic       alarm,
    output logic       scan_done,
    output logic       code_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [3:0] DEB_TC      = 4'(DEBOUNCE);

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] dbc_q [4];
    logic [3:0] dbc_d [4];
    logic [3:0] flag_q, flag_d;
    logic       alarm_q, alarm_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       sample_valid;
    logic       sample_bit;
    logic [3:0] dbc_inc;

    // Classify the returned code: only all-ones and all-zeros are meaningful.
    always_comb begin
        sample_valid = (result_in == 8'hFF) || (result_in == 8'h00);
        sample_bit   = (result_in == 8'hFF);
        dbc_inc      = dbc_q[ch_q] + 4'd1;
    end

    // Next-state, channel walk and debounce update.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        dbc_d   = dbc_q;
        flag_d  = flag_q;
        err_d   = err_q;
        done_d  = 1'b0;

        if (!enable) begin
            // Dropping enable discards any in-flight sample and rewinds to motor 0.
            state_d = ST_IDLE;
            ch_d    = 2'd0;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    ch_d    = 2'd0;
                    cnt_d   = 4'd0;
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_SAMPLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    state_d = ST_SETTLE;
                    cnt_d   = 4'd0;
                    ch_d    = ch_q + 2'd1;
                    done_d  = (ch_q == 2'd3);
                    if (sample_valid) begin
                        if (sample_bit == flag_q[ch_q]) begin
                            dbc_d[ch_q] = 4'd0;
                        end else if (dbc_inc == DEB_TC) begin
                            flag_d[ch_q] = ~flag_q[ch_q];
                            dbc_d[ch_q]  = 4'd0;
                        end else begin
                            dbc_d[ch_q] = dbc_inc;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ch_d    = 2'd0;
                    cnt_d   = 4'd0;
                end
            endcase
        end

        // Alarm follows the flags being written on this edge, not the old ones.
        alarm_d = |flag_d;
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= 2'd0;
            cnt_q   <= 4'd0;
            flag_q  <= 4'd0;
            alarm_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                dbc_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            alarm_q <= alarm_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int i = 0; i < 4; i++) begin
                dbc_q[i] <= dbc_d[i];
            end
        end
    end

    assign s1        = ch_q[1];
    assign s2        = ch_q[0];
    assign ovs_flag  = flag_q;
    assign alarm     = alarm_q;
    assign scan_done = done_q;
    assign code_err  = err_q;

endmodule

// File: tb/tb_motor_status_scanner.sv
// Directed bench for motor_status_scanner with a per-motor scoreboard of
// expected flag/alarm/error state after each sample.

module tb_motor_status_scanner;

    localparam int SETTLE_CYC = 2;
    localparam int DEBOUNCE   = 3;
    localparam int PERIOD_M   = SETTLE_CYC + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] result_in;
    logic       s1, s2;
    logic [3:0] ovs_flag;
    logic       alarm, scan_done, code_err;

    int checks   = 0;
    int failures = 0;

    logic [3:0] m_flag;
    int         m_cnt [4];
    logic       m_err;
    logic [5:0] exp_q [$];
    logic [7:0] m1_pat [6];
    logic [7:0] m0_pat [4];

    motor_status_scanner #(.SETTLE_CYC(SETTLE_CYC), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .result_in (result_in),
        .s1        (s1),
        .s2        (s2),
        .ovs_flag  (ovs_flag),
        .alarm     (alarm),
        .scan_done (scan_done),
        .code_err  (code_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flag = 4'b0000;
        m_err  = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic model_apply(input int m, input logic [7:0] code);
        logic v;
        if (code == 8'hFF || code == 8'h00) begin
            v = (code == 8'hFF);
            if (v == m_flag[m]) begin
                m_cnt[m] = 0;
            end else begin
                m_cnt[m] = m_cnt[m] + 1;
                if (m_cnt[m] == DEBOUNCE) begin
                    m_flag[m] = ~m_flag[m];
                    m_cnt[m]  = 0;
                end
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    // One full scan; expected post-sample state is queued before driving.
    task automatic run_scan(input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3, input bit fresh);
        logic [7:0] pat [4];
        logic [5:0] e;
        int n;
        pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
        for (int m = 0; m < 4; m++) begin
            model_apply(m, pat[m]);
            exp_q.push_back({m_flag, |m_flag, m_err});
        end
        for (int m = 0; m < 4; m++) begin
            check("sel", 32'({s1, s2}), 32'(m));
            n = 0;
            result_in = pat[m];
            while ({s1, s2} == 2'(m) && n < 20) begin
                tick();
                n++;
            end
            check("motor_period", 32'(n), (fresh && m == 0) ? 32'(PERIOD_M + 1) : 32'(PERIOD_M));
            e = exp_q.pop_front();
            check("ovs_flag", 32'(ovs_flag), 32'(e[5:2]));
            check("alarm", 32'(alarm), 32'(e[1]));
            check("code_err", 32'(code_err), 32'(e[0]));
            check("scan_done", 32'(scan_done), 32'(m == 3));
        end
    endtask

    // Step until the select reaches target, feeding samples that match current flags.
    task automatic advance_to(input int target);
        int n;
        logic [1:0] prev;
        logic [7:0] code;
        n = 0;
        while ({s1, s2} != 2'(target) && n < 40) begin
            prev = {s1, s2};
            code = m_flag[prev] ? 8'hFF : 8'h00;
            result_in = code;
            tick();
            n++;
            if ({s1, s2} != prev) model_apply(int'(prev), code);
        end
        check("advance_reach", 32'({s1, s2}), 32'(target));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"}, 32'({s1, s2}), 32'd0);
        check({tag, "_flag"}, 32'(ovs_flag), 32'd0);
        check({tag, "_alarm"}, 32'(alarm), 32'd0);
        check({tag, "_done"}, 32'(scan_done), 32'd0);
        check({tag, "_err"}, 32'(code_err), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        result_in = 8'h00;
        model_reset();
        m1_pat[0] = 8'hFF; m1_pat[1] = 8'hFF; m1_pat[2] = 8'h00;
        m1_pat[3] = 8'hFF; m1_pat[4] = 8'hFF; m1_pat[5] = 8'hFF;
        m0_pat[0] = 8'hFF; m0_pat[1] = 8'hFF; m0_pat[2] = 8'h5A; m0_pat[3] = 8'hFF;

        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        enable = 1'b1;

        // All-normal scans.
        run_scan(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        run_scan(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

        // Motor 2 overspeed; flag and alarm rise on the third scan.
        repeat (3) run_scan(8'h00, 8'h00, 8'hFF, 8'h00, 1'b0);

        // Motor 1 with an interrupting normal sample.
        for (int s = 0; s < 6; s++) run_scan(8'h00, m1_pat[s], 8'hFF, 8'h00, 1'b0);

        // Motor 0 with an invalid code in the middle of its run.
        for (int s = 0; s < 4; s++) run_scan(m0_pat[s], 8'hFF, 8'hFF, 8'h00, 1'b0);

        // Disable while motor 2 is settling, idle five cycles, restart.
        advance_to(2);
        tick();
        enable = 1'b0;
        tick();
        check("dis_sel", 32'({s1, s2}), 32'd0);
        check("dis_done", 32'(scan_done), 32'd0);
        check("dis_flag", 32'(ovs_flag), 32'(m_flag));
        check("dis_alarm", 32'(alarm), 32'(|m_flag));
        check("dis_err", 32'(code_err), 32'(m_err));
        repeat (4) tick();
        check("idle_sel", 32'({s1, s2}), 32'd0);
        check("idle_done", 32'(scan_done), 32'd0);
        enable = 1'b1;
        run_scan(8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1);

        // Disable during motor 3 SAMPLE: that sample is discarded.
        advance_to(3);
        tick();
        tick();
        result_in = 8'hFF;
        enable = 1'b0;
        tick();
        check("smp_dis_sel", 32'({s1, s2}), 32'd0);
        check("smp_dis_done", 32'(scan_done), 32'd0);
        check("smp_dis_flag", 32'(ovs_flag), 32'(m_flag));
        enable = 1'b1;
        run_scan(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        run_scan(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        run_scan(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);

        // Asynchronous reset in the middle of SETTLE.
        tick();
        #1;
        rst_n = 1'b0;
        #2;
        check_all_zero("async_rst");
        model_reset();
        #2;
        rst_n = 1'b1;
        run_scan(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
